seg_scan: RTL and testbench
===========================

# seg_scan

Time-multiplexed seven-segment display driver that consumes the BCD/hex digit values produced by the counter chain (seconds/minutes) and drives a common-anode N-digit display. It snapshots all digit inputs once per scan frame to prevent tearing and supports per-digit blinking and decimal points. It sits at the output end of the datapath, directly downstream of the counters, and drives the board anode and cathode pins.

## Interface
- SCAN_DIV, default 100000: clock cycles per digit dwell, ≥2.
- N_DIGITS, default 4: number of digits, ≥2.
- BLINK_FRAMES, default 100: frames per blink half-period, ≥1.
- i_clk  in  1: system clock; the only clock.
- i_rst_n  in  1: asynchronous, active-low reset.
- i_en  in  1: display enable; low blanks all anodes; scanning continues.
- i_digits  in  4*N_DIGITS: digit values; digit k is [4k+3:4k]; digit 0 is rightmost.
- i_blink  in  N_DIGITS: per-digit blink request.
- i_dp  in  N_DIGITS: per-digit decimal point request, active-high.
- o_an  out  N_DIGITS: anode selects, active-low, one-hot-low when enabled.
- o_seg  out  7: cathodes {g,f,e,d,c,b,a}, active-low.
- o_dp  out  1: decimal point cathode, active-low.

## Operation
- Prescaler r_pre counts 0..SCAN_DIV-1 every cycle and wraps to 0. scan_tick = (r_pre == SCAN_DIV-1).
- Digit index r_idx advances on scan_tick and wraps N_DIGITS-1 → 0. frame_tick = scan_tick && r_idx == N_DIGITS-1.
- On frame_tick, snap_digits, snap_blink, and snap_dp register i_digits, i_blink, and i_dp. Input changes between frame_ticks are never visible mid-frame.
- Frame counter r_frm counts frame_ticks 0..BLINK_FRAMES-1. On wrap, r_phase toggles.
- Digit k is blanked when snap_blink[k] && r_phase. When blanked, o_seg = 7'h7F and o_dp = 1. The anode stays driven.
- Hex decoding (active-low, bit0 = a): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Outputs are registered every cycle from r_idx and the snapshots:
  - o_an <= i_en ? ~(1<<r_idx) : all ones.
  - o_seg <= decode(snap_digits[r_idx]), or 7'h7F if blanked.
  - o_dp <= ~snap_dp[r_idx], or 1 if blanked.
- Reset values:
  - r_pre, r_idx, r_frm, r_phase, and all snapshots = 0.
  - o_an = all ones, o_seg = 7'h7F, o_dp = 1.
- Reset mid-frame discards the snapshot and restarts at digit 0 with blanked outputs.
- Simultaneous frame_tick and blink wrap: the new snapshot and the toggled phase take effect together, on the same edge.

## Timing
- Output latency: 1 cycle from an r_idx change to o_an/o_seg.
- After reset release, the first edge drives o_an = ~1 (digit 0 on) with o_seg = 7'h40 ("0").
- Digit dwell is SCAN_DIV cycles. Frame length is N_DIGITS*SCAN_DIV cycles.
- Blink half-period is BLINK_FRAMES frames.
- Input-to-display latency is up to one frame plus 1 cycle, after the next frame_tick.
- i_en acts on o_an one cycle after sampling; it has no effect on counters or snapshots.
- At most one anode is low in any cycle. There is no glitch between digits, because o_an and o_seg change on the same edge.

## Structure
- Shared package seg_pkg holds the SEG_BLANK = 7'h7F constant and the 16-entry active-low hex segment table.
- Sub-module hex_to_seg: a combinational 4-bit to 7-bit decoder using the package table; instantiated once, indexed by r_idx.
- seg_scan contains the prescaler, index counter, frame/blink counter, snapshot registers, and output registers.

## Test plan
- Reset and scan (SCAN_DIV=4, N_DIGITS=4), i_digits=16'h1234, i_en=1 → first frame shows 0000. From cycle 17, o_an steps E,D,B,7 every 4 cycles with o_seg 19,30,24,79 (digits 4,3,2,1).
- Tearing: change i_digits from 16'h1234 to 16'h5678 mid-frame → the remainder of that frame still shows 1234. 5678 appears starting with the next digit-0 dwell.
- Blink (BLINK_FRAMES=2), i_blink=4'b0001 → digit 0 shows its value for 2 frames, then o_seg=7F/o_dp=1 for 2 frames while o_an still selects it. Other digits are unaffected.
- Enable/dp: i_en=0 → o_an=F one cycle later while r_idx keeps advancing. i_dp=4'b0100 → o_dp=0 only while o_an=B.
- Hex/reset: i_digits=16'hFA0E → o_seg 06,40,08,0E. Assert i_rst_n low mid-dwell → outputs go to F/7F/1 immediately (asynchronously), and scanning restarts at digit 0.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared seven-segment constants and hex glyph table
package seg_pkg;

  // All cathodes off (active-low), used for blanking and reset.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low glyphs {g,f,e,d,c,b,a}; entry n is the glyph for hex value n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  function automatic logic [6:0] hex_seg(input logic [3:0] value);
    return SEG_TABLE[value];
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// rtl/seg_scan_if.sv - digit inputs and display pins of the scan driver
interface seg_scan_if #(
  parameter int N_DIGITS = 4
);

  logic                  i_en;
  logic [4*N_DIGITS-1:0] i_digits;
  logic [N_DIGITS-1:0]   i_blink;
  logic [N_DIGITS-1:0]   i_dp;
  logic [N_DIGITS-1:0]   o_an;
  logic [6:0]            o_seg;
  logic                  o_dp;

  // Source of digit data and observer of the display pins.
  modport master (
    output i_en, i_digits, i_blink, i_dp,
    input  o_an, o_seg, o_dp
  );

  // The display driver itself.
  modport slave (
    input  i_en, i_digits, i_blink, i_dp,
    output o_an, o_seg, o_dp
  );

endinterface

// File: rtl/hex_to_seg.sv
// rtl/hex_to_seg.sv - combinational hex nibble to active-low segment decoder
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = hex_seg(digit);

endmodule

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - time-multiplexed common-anode seven-segment scan driver
module seg_scan
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int N_DIGITS     = 4,
  parameter int BLINK_FRAMES = 100
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  seg_scan_if.slave   bus
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PRE_W-1:0]      r_pre;
  logic [IDX_W-1:0]      r_idx;
  logic [FRM_W-1:0]      r_frm;
  logic                  r_phase;
  logic [4*N_DIGITS-1:0] snap_digits;
  logic [N_DIGITS-1:0]   snap_blink;
  logic [N_DIGITS-1:0]   snap_dp;

  logic                  scan_tick;
  logic                  frame_tick;
  logic                  frm_wrap;
  logic [3:0]            cur_digit;
  logic [6:0]            dec_seg;
  logic                  blanked;
  logic [N_DIGITS-1:0]   an_sel;

  assign scan_tick  = (r_pre == PRE_W'(SCAN_DIV - 1));
  assign frame_tick = scan_tick && (r_idx == IDX_W'(N_DIGITS - 1));
  assign frm_wrap   = (r_frm == FRM_W'(BLINK_FRAMES - 1));

  // Select the snapshot fields of the digit currently being scanned.
  always_comb begin
    cur_digit = snap_digits[4*r_idx +: 4];
    blanked   = snap_blink[r_idx] && r_phase;
    an_sel    = ~(N_DIGITS'(1) << r_idx);
  end

  hex_to_seg u_dec (
    .digit (cur_digit),
    .seg   (dec_seg)
  );

  // Prescaler and digit index: dwell SCAN_DIV cycles per digit, then advance.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pre <= '0;
      r_idx <= '0;
    end else begin
      if (scan_tick) begin
        r_pre <= '0;
        r_idx <= (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  // Frame counter and blink phase; phase flips every BLINK_FRAMES frames.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frm   <= '0;
      r_phase <= 1'b0;
    end else if (frame_tick) begin
      if (frm_wrap) begin
        r_frm   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_frm   <= r_frm + 1'b1;
      end
    end
  end

  // Capture all digit data once per frame so a frame never mixes old and new values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      snap_digits <= '0;
      snap_blink  <= '0;
      snap_dp     <= '0;
    end else if (frame_tick) begin
      snap_digits <= bus.i_digits;
      snap_blink  <= bus.i_blink;
      snap_dp     <= bus.i_dp;
    end
  end

  // Registered pins: anode and cathodes update on the same edge to avoid ghosting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_an  <= '1;
      bus.o_seg <= SEG_BLANK;
      bus.o_dp  <= 1'b1;
    end else begin
      bus.o_an  <= bus.i_en ? an_sel : '1;
      bus.o_seg <= blanked ? SEG_BLANK : dec_seg;
      bus.o_dp  <= blanked ? 1'b1 : ~snap_dp[r_idx];
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - self-checking bench for seg_scan with a time-based reference model
module tb_seg_scan;

  localparam int SD    = 4;
  localparam int ND    = 4;
  localparam int BF    = 2;
  localparam int FRAME = SD * ND;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  seg_scan_if #(.N_DIGITS(ND)) bus ();

  seg_scan #(
    .SCAN_DIV     (SD),
    .N_DIGITS     (ND),
    .BLINK_FRAMES (BF)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ref_glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  // Reference model: everything is derived from the number of edges since reset.
  int          m_n;
  int          m_idx;
  int          m_ph;
  logic [15:0] m_dig;
  logic [3:0]  m_blink;
  logic [3:0]  m_dp;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [3:0]  m_d;
  logic        m_blank;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n = 0; m_dig = '0; m_blink = '0; m_dp = '0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
    end else begin
      m_idx   = (m_n / SD) % ND;
      m_ph    = ((m_n / FRAME) / BF) % 2;
      m_d     = m_dig[m_idx*4 +: 4];
      m_blank = m_blink[m_idx] && (m_ph == 1);
      exp_an  = bus.i_en ? ~(4'b0001 << m_idx) : 4'hF;
      exp_seg = m_blank ? 7'h7F : ref_glyph(m_d);
      exp_dp  = m_blank ? 1'b1 : ~m_dp[m_idx];
      m_n     = m_n + 1;
      if (m_n % FRAME == 0) begin
        m_dig = bus.i_digits; m_blink = bus.i_blink; m_dp = bus.i_dp;
      end
    end
  end

  // Stimulus-only reset sequence; release lands on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.i_en = 1'b1; bus.i_digits = 16'h1234; bus.i_blink = '0; bus.i_dp = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.o_an, bus.o_seg, bus.o_dp} !== {4'hF, 7'h7F, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state an=%h seg=%h dp=%b want an=F seg=7F dp=1", bus.o_an, bus.o_seg, bus.o_dp);
    end
  endtask

  task automatic test_scan();
    rst_n = 1'b1;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.o_an, bus.o_seg, bus.o_dp} !== {exp_an, exp_seg, exp_dp}) begin
        n_fail++;
        $display("FAIL scan edge=%0d an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                 m_n, bus.o_an, bus.o_seg, bus.o_dp, exp_an, exp_seg, exp_dp);
      end
      if (m_n == 1 || m_n == 17 || m_n == 21 || m_n == 25 || m_n == 29) begin
        logic [3:0] wa; logic [6:0] ws;
        case (m_n)
          1:  begin wa = 4'hE; ws = 7'h40; end
          17: begin wa = 4'hE; ws = 7'h19; end
          21: begin wa = 4'hD; ws = 7'h30; end
          25: begin wa = 4'hB; ws = 7'h24; end
          default: begin wa = 4'h7; ws = 7'h79; end
        endcase
        n_cmp++;
        if ({bus.o_an, bus.o_seg} !== {wa, ws}) begin
          n_fail++;
          $display("FAIL scan_fixed edge=%0d an=%h seg=%h want an=%h seg=%h", m_n, bus.o_an, bus.o_seg, wa, ws);
        end
      end
    end
  endtask

  task automatic test_tearing();
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.o_an, bus.o_seg, bus.o_dp} !== {exp_an, exp_seg, exp_dp}) begin
        n_fail++;
        $display("FAIL tearing edge=%0d an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                 m_n, bus.o_an, bus.o_seg, bus.o_dp, exp_an, exp_seg, exp_dp);
      end
      if (m_n == 45) begin
        n_cmp++;
        if ({bus.o_an, bus.o_seg} !== {4'h7, 7'h79}) begin
          n_fail++;
          $display("FAIL tearing_old edge=45 an=%h seg=%h want an=7 seg=79", bus.o_an, bus.o_seg);
        end
      end
      if (m_n == 49 || m_n == 53) begin
        n_cmp++;
        if (bus.o_seg !== ((m_n == 49) ? 7'h00 : 7'h78)) begin
          n_fail++;
          $display("FAIL tearing_new edge=%0d seg=%h want %h", m_n, bus.o_seg, (m_n == 49) ? 7'h00 : 7'h78);
        end
      end
      if (m_n == 38) bus.i_digits = 16'h5678;
    end
  endtask

  task automatic test_blink();
    bus.i_digits = 16'h1234; bus.i_blink = 4'b0001; bus.i_dp = '0; bus.i_en = 1'b1;
    do_reset();
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.o_an, bus.o_seg, bus.o_dp} !== {exp_an, exp_seg, exp_dp}) begin
        n_fail++;
        $display("FAIL blink edge=%0d an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                 m_n, bus.o_an, bus.o_seg, bus.o_dp, exp_an, exp_seg, exp_dp);
      end
      if (m_n == 17 || m_n == 33 || m_n == 37 || m_n == 49 || m_n == 65) begin
        logic [3:0] wa; logic [6:0] ws;
        case (m_n)
          17: begin wa = 4'hE; ws = 7'h19; end
          33: begin wa = 4'hE; ws = 7'h7F; end
          37: begin wa = 4'hD; ws = 7'h30; end
          49: begin wa = 4'hE; ws = 7'h7F; end
          default: begin wa = 4'hE; ws = 7'h19; end
        endcase
        n_cmp++;
        if ({bus.o_an, bus.o_seg, bus.o_dp} !== {wa, ws, 1'b1}) begin
          n_fail++;
          $display("FAIL blink_fixed edge=%0d an=%h seg=%h dp=%b want an=%h seg=%h dp=1",
                   m_n, bus.o_an, bus.o_seg, bus.o_dp, wa, ws);
        end
      end
    end
  endtask

  task automatic test_enable_dp();
    bus.i_digits = 16'h1234; bus.i_blink = '0; bus.i_dp = 4'b0100; bus.i_en = 1'b1;
    do_reset();
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.o_an, bus.o_seg, bus.o_dp} !== {exp_an, exp_seg, exp_dp}) begin
        n_fail++;
        $display("FAIL enable_dp edge=%0d an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                 m_n, bus.o_an, bus.o_seg, bus.o_dp, exp_an, exp_seg, exp_dp);
      end
      if (m_n > 16 && !(m_n >= 37 && m_n <= 44)) begin
        n_cmp++;
        if ((bus.o_dp === 1'b0) !== (bus.o_an === 4'hB)) begin
          n_fail++;
          $display("FAIL dp_only_on_digit2 edge=%0d an=%h dp=%b want dp=0 exactly when an=B", m_n, bus.o_an, bus.o_dp);
        end
      end
      if (m_n == 37 || m_n == 45) begin
        n_cmp++;
        if (bus.o_an !== ((m_n == 37) ? 4'hF : 4'h7)) begin
          n_fail++;
          $display("FAIL enable_an edge=%0d an=%h want %h", m_n, bus.o_an, (m_n == 37) ? 4'hF : 4'h7);
        end
      end
      if (m_n == 36) bus.i_en = 1'b0;
      if (m_n == 44) bus.i_en = 1'b1;
    end
  endtask

  task automatic test_hex_reset();
    bus.i_digits = 16'hFA0E; bus.i_blink = '0; bus.i_dp = '0; bus.i_en = 1'b1;
    do_reset();
    for (int c = 0; c < 38; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.o_an, bus.o_seg, bus.o_dp} !== {exp_an, exp_seg, exp_dp}) begin
        n_fail++;
        $display("FAIL hex edge=%0d an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                 m_n, bus.o_an, bus.o_seg, bus.o_dp, exp_an, exp_seg, exp_dp);
      end
      if (m_n == 17 || m_n == 21 || m_n == 25 || m_n == 29) begin
        logic [6:0] ws;
        case (m_n)
          17: ws = 7'h06;
          21: ws = 7'h40;
          25: ws = 7'h08;
          default: ws = 7'h0E;
        endcase
        n_cmp++;
        if (bus.o_seg !== ws) begin
          n_fail++;
          $display("FAIL hex_fixed edge=%0d seg=%h want %h", m_n, bus.o_seg, ws);
        end
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.o_an, bus.o_seg, bus.o_dp} !== {4'hF, 7'h7F, 1'b1}) begin
      n_fail++;
      $display("FAIL async_reset an=%h seg=%h dp=%b want an=F seg=7F dp=1", bus.o_an, bus.o_seg, bus.o_dp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.o_an, bus.o_seg, bus.o_dp} !== {exp_an, exp_seg, exp_dp}) begin
        n_fail++;
        $display("FAIL restart edge=%0d an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                 m_n, bus.o_an, bus.o_seg, bus.o_dp, exp_an, exp_seg, exp_dp);
      end
      if (m_n == 1 || m_n == 5) begin
        n_cmp++;
        if ({bus.o_an, bus.o_seg} !== {(m_n == 1) ? 4'hE : 4'hD, 7'h40}) begin
          n_fail++;
          $display("FAIL restart_fixed edge=%0d an=%h seg=%h want an=%h seg=40",
                   m_n, bus.o_an, bus.o_seg, (m_n == 1) ? 4'hE : 4'hD);
        end
      end
    end
  endtask

  task automatic test_random();
    int zeros;
    bus.i_digits = 16'($urandom); bus.i_blink = 4'($urandom); bus.i_dp = 4'($urandom); bus.i_en = 1'b1;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.o_an, bus.o_seg, bus.o_dp} !== {exp_an, exp_seg, exp_dp}) begin
        n_fail++;
        $display("FAIL random edge=%0d an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                 m_n, bus.o_an, bus.o_seg, bus.o_dp, exp_an, exp_seg, exp_dp);
      end
      zeros = 0;
      for (int b = 0; b < ND; b++) if (bus.o_an[b] === 1'b0) zeros++;
      n_cmp++;
      if (zeros > 1) begin
        n_fail++;
        $display("FAIL one_anode edge=%0d an=%h want at most one low bit", m_n, bus.o_an);
      end
      if ($urandom_range(4, 0) == 0) begin
        bus.i_digits = 16'($urandom);
        bus.i_blink  = 4'($urandom);
        bus.i_dp     = 4'($urandom);
      end
      if ($urandom_range(19, 0) == 0) bus.i_en = ~bus.i_en;
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_scan();
    test_tearing();
    test_blink();
    test_enable_dp();
    test_hex_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
